// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register, next-PC selection with trap,
// return, jump/call and branch requests, and a circular return-address stack.
module pc_unit #(
  parameter int                 WIDTH        = 32,
  parameter int                 INC          = 4,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]   TRAP_VECTOR  = 'h80,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Stall,
  input  logic                        Branch,
  input  logic [WIDTH-1:0]            Branch_target,
  input  logic                        Jump,
  input  logic                        Call,
  input  logic [WIDTH-1:0]            Jump_target,
  input  logic                        Ret,
  input  logic [WIDTH-1:0]            Ret_target,
  input  logic                        Trap,
  output logic [WIDTH-1:0]            addr,
  output logic [WIDTH-1:0]            Pc_plus,
  output logic [$clog2(RAS_DEPTH):0]  Ras_count,
  output logic                        Ras_miss,
  output logic                        Misalign
);

  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;

  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ret_tgt;
  logic             push;
  logic             pop;
  logic             miss_nxt;
  logic             misal_nxt;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] t);
    return |(t & ALIGN_MASK);
  endfunction

  assign Pc_plus   = addr + WIDTH'(INC);
  assign ras_top   = ras_mem[wr_ptr - PTR_W'(1)];
  assign ras_empty = (Ras_count == '0);
  assign ret_tgt   = ras_empty ? Ret_target : ras_top;

  // A misaligned target overrides the request, so it neither pushes nor pops.
  always_comb begin
    next_pc   = addr;
    push      = 1'b0;
    pop       = 1'b0;
    miss_nxt  = 1'b0;
    misal_nxt = 1'b0;
    if (Trap) begin
      next_pc = TRAP_VECTOR;
    end else if (Stall) begin
      next_pc = addr;
    end else if (Ret) begin
      if (is_misaligned(ret_tgt)) begin
        next_pc   = TRAP_VECTOR;
        misal_nxt = 1'b1;
      end else begin
        next_pc  = ret_tgt;
        pop      = !ras_empty;
        miss_nxt = ras_empty;
      end
    end else if (Call || Jump) begin
      if (is_misaligned(Jump_target)) begin
        next_pc   = TRAP_VECTOR;
        misal_nxt = 1'b1;
      end else begin
        next_pc = Jump_target;
        push    = Call;
      end
    end else if (Branch) begin
      if (is_misaligned(Branch_target)) begin
        next_pc   = TRAP_VECTOR;
        misal_nxt = 1'b1;
      end else begin
        next_pc = Branch_target;
      end
    end else begin
      next_pc = Pc_plus;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr      <= RESET_VECTOR;
      wr_ptr    <= '0;
      Ras_count <= '0;
      Ras_miss  <= 1'b0;
      Misalign  <= 1'b0;
    end else begin
      addr     <= next_pc;
      Ras_miss <= miss_nxt;
      Misalign <= misal_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (Ras_count != CNT_FULL) Ras_count <= Ras_count + CNT_W'(1);
      end else if (pop) begin
        wr_ptr    <= wr_ptr - PTR_W'(1);
        Ras_count <= Ras_count - CNT_W'(1);
      end
    end
  end

  // Stack contents carry no reset; the count alone defines which entries are valid.
  always_ff @(posedge Clock) begin
    if (push) ras_mem[wr_ptr] <= Pc_plus;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus random requests,
// checked against a queue-based return-stack model.
module tb_pc_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Stall = 1'b0, Branch = 1'b0, Jump = 1'b0, Call = 1'b0;
  logic             Ret = 1'b0, Trap = 1'b0;
  logic [WIDTH-1:0] Branch_target = '0, Jump_target = '0, Ret_target = '0;
  logic [WIDTH-1:0] addr, Pc_plus;
  logic [2:0]       Ras_count;
  logic             Ras_miss, Misalign;

  pc_unit #(.WIDTH(WIDTH), .INC(4), .RESET_VECTOR('0), .TRAP_VECTOR('h80), .RAS_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .Branch_target(Branch_target), .Jump(Jump), .Call(Call),
    .Jump_target(Jump_target), .Ret(Ret), .Ret_target(Ret_target), .Trap(Trap),
    .addr(addr), .Pc_plus(Pc_plus), .Ras_count(Ras_count),
    .Ras_miss(Ras_miss), .Misalign(Misalign)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [WIDTH-1:0] pc;
    int               cnt;
    logic             miss;
    logic             mis;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] m_pc;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the stack is a plain queue, newest at the back,
  // and the oldest entry is dropped once it holds more than DEPTH values.
  task automatic drive(input logic st, input logic br, input logic [WIDTH-1:0] bt,
                       input logic jp, input logic ca, input logic [WIDTH-1:0] jt,
                       input logic rt, input logic [WIDTH-1:0] rtt, input logic tr);
    exp_t             e;
    logic [WIDTH-1:0] tgt;
    Stall = st; Branch = br; Branch_target = bt; Jump = jp; Call = ca;
    Jump_target = jt; Ret = rt; Ret_target = rtt; Trap = tr;
    e.miss = 1'b0;
    e.mis  = 1'b0;
    if (tr) m_pc = 'h80;
    else if (st) m_pc = m_pc;
    else if (rt) begin
      tgt = (stk.size() > 0) ? stk[$] : rtt;
      if (tgt % 4 != 0) begin m_pc = 'h80; e.mis = 1'b1; end
      else begin
        m_pc = tgt;
        if (stk.size() > 0) void'(stk.pop_back());
        else e.miss = 1'b1;
      end
    end else if (jp || ca) begin
      if (jt % 4 != 0) begin m_pc = 'h80; e.mis = 1'b1; end
      else begin
        if (ca) begin
          stk.push_back(m_pc + 4);
          if (stk.size() > DEPTH) void'(stk.pop_front());
        end
        m_pc = jt;
      end
    end else if (br) begin
      if (bt % 4 != 0) begin m_pc = 'h80; e.mis = 1'b1; end
      else m_pc = bt;
    end else m_pc = m_pc + 4;
    e.pc  = m_pc;
    e.cnt = stk.size();
    exp_q.push_back(e);
    @(negedge Clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic jump_to(input logic [WIDTH-1:0] t);
    drive(0, 0, 0, 1, 0, t, 0, 0, 0);
  endtask
  task automatic call_to(input logic [WIDTH-1:0] t);
    drive(0, 0, 0, 0, 1, t, 0, 0, 0);
  endtask
  task automatic ret_with(input logic [WIDTH-1:0] t);
    drive(0, 0, 0, 0, 0, 0, 1, t, 0);
  endtask

  // Called just after a falling edge; asserts reset between edges and checks
  // the asynchronous effect before any clock edge arrives.
  task automatic do_reset();
    Stall = 0; Branch = 0; Jump = 0; Call = 0; Ret = 0; Trap = 0;
    #2 Reset = 1'b0;
    #1;
    chk("reset_addr", addr, '0);
    chk("reset_count", WIDTH'(Ras_count), '0);
    chk("reset_flags", WIDTH'({Ras_miss, Misalign}), '0);
    exp_q.delete();
    stk.delete();
    m_pc = '0;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  // Monitor: every clock the DUT presents a new state; compare it with the
  // oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (Reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("addr", addr, e.pc);
        chk("pc_plus", Pc_plus, e.pc + 4);
        chk("ras_count", WIDTH'(Ras_count), WIDTH'(e.cnt));
        chk("ras_miss", WIDTH'(Ras_miss), WIDTH'(e.miss));
        chk("misalign", WIDTH'(Misalign), WIDTH'(e.mis));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] t;
    m_pc = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) idle();
    do_reset();
    repeat (4) idle();

    // Priority: trap beats everything, then jump beats branch
    jump_to('h100);
    drive(0, 1, 'h200, 1, 0, 'h300, 0, 0, 1);
    jump_to('h100);
    drive(0, 1, 'h200, 1, 0, 'h300, 0, 0, 0);

    // Call/return nesting
    do_reset();
    jump_to('h10);
    call_to('h40);
    call_to('h90);
    ret_with('h700);
    ret_with('h700);

    // Overflow then underflow
    do_reset();
    for (int i = 1; i <= 5; i++) call_to(WIDTH'(i) << 12);
    for (int i = 0; i < 4; i++) ret_with('h500);
    ret_with('h500);
    idle();

    // Stall holds against jump; trap overrides stall
    call_to('h600);
    repeat (3) drive(1, 0, 0, 1, 0, 'h300, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 'h300, 1, 'h40, 1);

    // Misaligned branch, misaligned call, wrap at top of address space
    drive(0, 1, 'h202, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 'h3002, 0, 0, 0);
    jump_to('hFFFF_FFFC);
    idle();
    idle();

    // Random traffic, mostly aligned targets with occasional misalignment
    for (int n = 0; n < 400; n++) begin
      logic st, br, jp, ca, rt, tr;
      logic [WIDTH-1:0] bt, jt, rtt;
      st = ($urandom_range(0, 9) == 0);
      tr = ($urandom_range(0, 24) == 0);
      br = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 5) == 0);
      ca = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 3) == 0);
      t  = $urandom;
      bt = ($urandom_range(0, 7) == 0) ? t : (t & ~32'h3);
      t  = $urandom;
      jt = ($urandom_range(0, 7) == 0) ? t : (t & ~32'h3);
      t  = $urandom;
      rtt = ($urandom_range(0, 7) == 0) ? t : (t & ~32'h3);
      drive(st, br, bt, jp, ca, jt, rt, rtt, tr);
      if (n == 200) do_reset();
    end

    idle();
    @(posedge Clock);
    #2;
    chk("scoreboard_drained", WIDTH'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle CPU: holds the fetch address, computes the next address from sequential, branch, jump, call, return and trap requests, and keeps a circular return-address stack (RAS) for call/return prediction. It replaces the plain PC register between the next-PC logic and instruction memory. The unit adds stall hold, alignment checking and a trap vector.

## Interface

Parameters:
- WIDTH, 32: address width in bits.
- INC, 4: sequential increment in bytes. Must be a power of two and at least 1.
- RESET_VECTOR, 0: PC value during and after reset.
- TRAP_VECTOR, 32'h0000_0080: PC loaded on a trap or misaligned target.
- RAS_DEPTH, 4: number of return-stack entries. Must be a power of two and at least 2.

Ports:
- Clock, input, 1: rising-edge clock.
- Reset, input, 1: asynchronous, active-low reset.
- Stall, input, 1: hold all state this cycle.
- Branch, input, 1: conditional branch taken.
- Branch_target, input, WIDTH: branch destination.
- Jump, input, 1: unconditional jump.
- Call, input, 1: jump-and-link. Qualifies Jump_target and pushes the return address.
- Jump_target, input, WIDTH: jump or call destination.
- Ret, input, 1: return. Pops the RAS.
- Ret_target, input, WIDTH: architectural return address, used when the RAS is empty.
- Trap, input, 1: exception request.
- addr, output, WIDTH: current fetch address.
- Pc_plus, output, WIDTH: addr + INC, combinational; this is the link value.
- Ras_count, output, clog2(RAS_DEPTH)+1: number of valid RAS entries.
- Ras_miss, output, 1: registered one-cycle pulse. Set when a Ret found the RAS empty.
- Misalign, output, 1: registered one-cycle pulse. Set when a selected target had nonzero low log2(INC) bits.

## Operation

- Next-PC priority, highest first:
  - Trap: TRAP_VECTOR.
  - Ret: RAS top, or Ret_target if the RAS is empty.
  - Call or Jump: Jump_target.
  - Branch: Branch_target.
  - Otherwise: addr + INC.
- Lower-priority requests in the same cycle are ignored. They cause no stack effect.
- Alignment:
  - If the selected Ret, Jump, Call or Branch target has nonzero low log2(INC) bits, next PC is TRAP_VECTOR.
  - Misalign pulses in that case.
  - No push or pop occurs in that cycle.
- Call (when not overridden) pushes Pc_plus:
  - Write at the write pointer, advance the pointer modulo RAS_DEPTH, and increment Ras_count up to RAS_DEPTH.
  - When the stack is full, the push overwrites the oldest entry and Ras_count stays at RAS_DEPTH.
- Ret (when not overridden) with Ras_count > 0:
  - Use the entry at write pointer − 1 as the target.
  - Decrement the write pointer modulo RAS_DEPTH and decrement Ras_count.
- Ret with Ras_count == 0:
  - Use Ret_target as the target.
  - Pointer and count are unchanged; Ras_miss pulses.
- Call and Ret together: Ret wins and Call is ignored.
- Stall:
  - addr, the RAS, the pointer and the count hold.
  - Ras_miss and Misalign clear.
  - All requests are ignored except Trap.
- Trap overrides Stall. It loads TRAP_VECTOR and leaves the RAS untouched.
- PC arithmetic is modulo 2^WIDTH. addr + INC wraps to 0 at the top of the address space, with no flag.

## Timing

- Reset asserted (Reset = 0) takes effect immediately, with no clock needed:
  - addr = RESET_VECTOR; Ras_count = 0; write pointer = 0.
  - Ras_miss = 0; Misalign = 0.
  - RAS entry contents are don't-care.
- Reset asserted mid-operation discards any pending request and all stack contents.
- After deassertion, the first rising edge performs a normal update from RESET_VECTOR.
- addr, Ras_count and the pulse flags all update on the rising edge of Clock.
- The next PC is a combinational function of the inputs and current state.
- Latency: a request in cycle n appears on addr in cycle n+1.
- Ras_miss and Misalign are asserted in cycle n+1 for exactly one cycle.
- Pc_plus follows addr combinationally in the same cycle.
- A Call in cycle n followed by a Ret in cycle n+1 returns the value pushed in cycle n (back-to-back, no bubble).

## Test plan

- Reset and sequential fetch: assert Reset low mid-cycle, then release it.
  - addr goes to 0 immediately, with no clock edge.
  - Over four idle clocks, addr steps 4, 8, 12, 16.
- Priority: at addr = 0x100, assert Branch (target 0x200), Jump (target 0x300) and Trap together.
  - addr becomes 0x80.
  - With Trap removed, the same inputs give addr = 0x300.
- Call/return nesting:
  - Call at 0x10 (target 0x40), then Call at 0x40 (target 0x90).
  - Ret gives 0x44 and Ret_target is ignored; the next Ret gives 0x14.
  - Ras_count goes 1, 2, 1, 0.
- RAS overflow and underflow (RAS_DEPTH = 4):
  - Five calls, then Rets return the newest four link values.
  - The fifth Ret with Ret_target = 0x500 gives addr = 0x500 and a one-cycle Ras_miss pulse.
- Stall versus Trap:
  - Stall for three cycles with Jump asserted: addr and Ras_count are unchanged.
  - Stall together with Trap: addr = 0x80.
- Misalignment and wrap:
  - Branch_target 0x202 gives addr = 0x80, a Misalign pulse, and no RAS change.
  - At addr = 0xFFFF_FFFC, an idle cycle gives addr = 0.
